issue_scheduler: RTL and testbench

Out-of-order issue controller for the dynamic core. It accepts renamed instructions from dispatch, tracks source-operand readiness per entry, and wakes entries on writeback tag broadcasts. Each cycle it selects one ready entry round-robin and presents it to a single execution port through a valid/ready handshake. It also owns occupancy accounting (full/empty/count) and flush.

---
 rtl/sched_pkg.sv | 39 +++
 rtl/issue_scheduler_if.sv | 62 ++++++
 rtl/issue_scheduler_rr_select.sv | 39 +++
 rtl/issue_scheduler.sv | 161 ++++++++++++++++
 tb/tb_issue_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sched_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg
// Shared types for the out-of-order issue scheduler.
//   ENTRY_INSTR_W / ENTRY_TAG_W : field widths of one scheduler entry
//   ZERO_TAG                    : register tag that is always available
//   entry_t                     : one scheduler table slot
//   src_ready_at_alloc()        : readiness of a source as it is written into
//                                 the table (dispatch flag, tag 0, or a
//                                 writeback of that tag in the same cycle)
// ---------------------------------------------------------------------------
package sched_pkg;

    localparam int ENTRY_INSTR_W = 32;
    localparam int ENTRY_TAG_W   = 5;

    localparam logic [ENTRY_TAG_W-1:0] ZERO_TAG = '0;

    typedef struct packed {
        logic                     valid;
        logic [ENTRY_INSTR_W-1:0] instr;
        logic [ENTRY_TAG_W-1:0]   src1;
        logic                     src1_rdy;
        logic [ENTRY_TAG_W-1:0]   src2;
        logic                     src2_rdy;
        logic [ENTRY_TAG_W-1:0]   dst;
    } entry_t;

    // A writeback of ZERO_TAG needs no special case here: tag 0 is already
    // forced ready, so the bypass term only matters for nonzero tags.
    function automatic logic src_ready_at_alloc(
        input logic [ENTRY_TAG_W-1:0] tag,
        input logic                   rdy,
        input logic                   wb_valid,
        input logic [ENTRY_TAG_W-1:0] wb_tag
    );
        return rdy | (tag == ZERO_TAG) | (wb_valid & (wb_tag == tag));
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// ---------------------------------------------------------------------------
// issue_scheduler_if
// Bundles the dispatch, writeback, issue and status signals of the scheduler.
//   master : the environment (dispatch stage, writeback bus, execution port)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface issue_scheduler_if
    import sched_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int INSTR_WIDTH = ENTRY_INSTR_W,
    parameter int TAG_WIDTH   = ENTRY_TAG_W,
    parameter int ID_WIDTH    = $clog2(DEPTH)
);

    logic                   flush;

    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [INSTR_WIDTH-1:0] alloc_instr;
    logic [TAG_WIDTH-1:0]   alloc_src1;
    logic                   alloc_src1_rdy;
    logic [TAG_WIDTH-1:0]   alloc_src2;
    logic                   alloc_src2_rdy;
    logic [TAG_WIDTH-1:0]   alloc_dst;

    logic                   wb_valid;
    logic [TAG_WIDTH-1:0]   wb_tag;

    logic                   issue_valid;
    logic                   issue_ready;
    logic [INSTR_WIDTH-1:0] issue_instr;
    logic [TAG_WIDTH-1:0]   issue_dst;
    logic [ID_WIDTH-1:0]    issue_id;

    logic [ID_WIDTH:0]      count;
    logic                   full;
    logic                   empty;

    modport master (
        output flush,
        output alloc_valid, alloc_instr, alloc_src1, alloc_src1_rdy,
        output alloc_src2, alloc_src2_rdy, alloc_dst,
        input  alloc_ready,
        output wb_valid, wb_tag,
        input  issue_valid, issue_instr, issue_dst, issue_id,
        output issue_ready,
        input  count, full, empty
    );

    modport slave (
        input  flush,
        input  alloc_valid, alloc_instr, alloc_src1, alloc_src1_rdy,
        input  alloc_src2, alloc_src2_rdy, alloc_dst,
        output alloc_ready,
        input  wb_valid, wb_tag,
        output issue_valid, issue_instr, issue_dst, issue_id,
        input  issue_ready,
        output count, full, empty
    );

endinterface

// File: rtl/issue_scheduler_rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker.
//   req    : one request bit per table entry
//   start  : index that has highest priority this cycle
//   found  : at least one request is set
//   winner : first requesting index at or after start, wrapping modulo DEPTH
// DEPTH must be a power of two so the final add wraps naturally.
// ---------------------------------------------------------------------------
module rr_select #(
    parameter int DEPTH    = 16,
    parameter int ID_WIDTH = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]    req,
    input  logic [ID_WIDTH-1:0] start,
    output logic                found,
    output logic [ID_WIDTH-1:0] winner
);

    logic [2*DEPTH-1:0]  req_twice;
    logic [DEPTH-1:0]    rotated;
    logic [ID_WIDTH-1:0] offset;

    // Rotate so that 'start' lands on bit 0, pick the lowest set bit, then
    // add 'start' back to map the offset to a real table index.
    always_comb begin
        req_twice = {req, req};
        rotated   = req_twice[start +: DEPTH];
        found     = |rotated;
        offset    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = ID_WIDTH'(i);
            end
        end
        winner = start + offset;
    end

endmodule

// File: rtl/issue_scheduler.sv
// ---------------------------------------------------------------------------
// issue_scheduler
// Out-of-order issue controller: holds renamed instructions until both source
// operands are available, then issues one per cycle round-robin into a single
// registered issue slot.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : flush, dispatch (alloc_*), writeback broadcast (wb_*),
//                 issue slot handshake (issue_*), occupancy (count/full/empty)
// ---------------------------------------------------------------------------
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int INSTR_WIDTH = ENTRY_INSTR_W,
    parameter int TAG_WIDTH   = ENTRY_TAG_W,
    parameter int ID_WIDTH    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    issue_scheduler_if.slave bus
);

    entry_t                 entry_q [DEPTH];
    entry_t                 entry_d [DEPTH];
    logic                   issue_valid_q, issue_valid_d;
    logic [INSTR_WIDTH-1:0] issue_instr_q, issue_instr_d;
    logic [TAG_WIDTH-1:0]   issue_dst_q,   issue_dst_d;
    logic [ID_WIDTH-1:0]    issue_id_q,    issue_id_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q,      rr_ptr_d;
    logic [ID_WIDTH:0]      count_q,       count_d;

    logic [DEPTH-1:0]       eligible;
    logic [ID_WIDTH-1:0]    alloc_idx;
    logic                   sel_found;
    logic [ID_WIDTH-1:0]    sel_idx;
    logic                   full;
    logic                   alloc_fire;
    logic                   issue_load;

    // Eligibility and the lowest free slot both look only at registered
    // state, so an entry woken or freed at an edge is usable one cycle later.
    always_comb begin
        alloc_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            eligible[i] = entry_q[i].valid & entry_q[i].src1_rdy & entry_q[i].src2_rdy;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entry_q[i].valid) begin
                alloc_idx = ID_WIDTH'(i);
            end
        end
    end

    rr_select #(
        .DEPTH    (DEPTH),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_select (
        .req    (eligible),
        .start  (rr_ptr_q),
        .found  (sel_found),
        .winner (sel_idx)
    );

    assign full       = (count_q == (ID_WIDTH + 1)'(DEPTH));
    assign alloc_fire = bus.alloc_valid & ~full & ~bus.flush;
    assign issue_load = (~issue_valid_q | bus.issue_ready) & sel_found;

    // Next-state of the table and issue slot. Flush wins over everything
    // except reset. The winner was valid before the edge and the allocated
    // slot was free, so the two updates never touch the same entry.
    always_comb begin
        entry_d       = entry_q;
        issue_valid_d = issue_valid_q;
        issue_instr_d = issue_instr_q;
        issue_dst_d   = issue_dst_q;
        issue_id_d    = issue_id_q;
        rr_ptr_d      = rr_ptr_q;
        count_d       = count_q;

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
            end
            issue_valid_d = 1'b0;
            rr_ptr_d      = '0;
            count_d       = '0;
        end else begin
            if (bus.wb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entry_q[i].valid && entry_q[i].src1 == bus.wb_tag) begin
                        entry_d[i].src1_rdy = 1'b1;
                    end
                    if (entry_q[i].valid && entry_q[i].src2 == bus.wb_tag) begin
                        entry_d[i].src2_rdy = 1'b1;
                    end
                end
            end

            if (issue_load) begin
                entry_d[sel_idx].valid = 1'b0;
                issue_valid_d          = 1'b1;
                issue_instr_d          = entry_q[sel_idx].instr;
                issue_dst_d            = entry_q[sel_idx].dst;
                issue_id_d             = sel_idx;
                rr_ptr_d               = sel_idx + ID_WIDTH'(1);
            end else if (bus.issue_ready) begin
                issue_valid_d = 1'b0;
            end

            if (alloc_fire) begin
                entry_d[alloc_idx].valid    = 1'b1;
                entry_d[alloc_idx].instr    = bus.alloc_instr;
                entry_d[alloc_idx].src1     = bus.alloc_src1;
                entry_d[alloc_idx].src1_rdy = src_ready_at_alloc(bus.alloc_src1, bus.alloc_src1_rdy,
                                                                 bus.wb_valid, bus.wb_tag);
                entry_d[alloc_idx].src2     = bus.alloc_src2;
                entry_d[alloc_idx].src2_rdy = src_ready_at_alloc(bus.alloc_src2, bus.alloc_src2_rdy,
                                                                 bus.wb_valid, bus.wb_tag);
                entry_d[alloc_idx].dst      = bus.alloc_dst;
            end

            case ({alloc_fire, issue_load})
                2'b10:   count_d = count_q + (ID_WIDTH + 1)'(1);
                2'b01:   count_d = count_q - (ID_WIDTH + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_instr_q <= '0;
            issue_dst_q   <= '0;
            issue_id_q    <= '0;
            rr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            entry_q       <= entry_d;
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
            issue_dst_q   <= issue_dst_d;
            issue_id_q    <= issue_id_d;
            rr_ptr_q      <= rr_ptr_d;
            count_q       <= count_d;
        end
    end

    assign bus.alloc_ready = ~full & ~bus.flush;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_instr = issue_instr_q;
    assign bus.issue_dst   = issue_dst_q;
    assign bus.issue_id    = issue_id_q;
    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.empty       = (count_q == '0);

endmodule

// File: tb/tb_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_issue_scheduler
// Directed scenarios followed by random traffic. Inputs change 2ns after each
// rising edge; a monitor samples on the falling edge. The reference model is
// an array-of-entries description of the scheduler's rules; every expected
// issue transfer is queued and popped by the monitor when the DUT hands one
// over.
// ---------------------------------------------------------------------------
module tb_issue_scheduler;

    localparam int DEPTH = 16;

    logic clk;
    logic resetn;

    issue_scheduler_if #(.DEPTH(DEPTH)) bus ();

    issue_scheduler #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  dst;
        int          id;
    } iss_t;

    iss_t exp_q[$];
    int   obs_ids[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    bit          m_known = 0;
    bit          m_valid [DEPTH];
    logic [31:0] m_instr [DEPTH];
    logic [4:0]  m_s1    [DEPTH];
    logic [4:0]  m_s2    [DEPTH];
    logic [4:0]  m_dst   [DEPTH];
    bit          m_r1    [DEPTH];
    bit          m_r2    [DEPTH];
    bit          m_slot_v;
    logic [31:0] m_slot_instr;
    logic [4:0]  m_slot_dst;
    int          m_slot_id;
    int          m_rr;
    int          m_count;

    // Expected outputs for the current cycle, taken from the model before
    // it advances.
    bit          chk_en = 0;
    bit          e_iv, e_ar, e_full, e_empty;
    int          e_count;
    logic [31:0] e_instr;
    logic [4:0]  e_dst;
    int          e_id;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge given this cycle's inputs.
    task automatic modelEdge(input logic av, input logic [31:0] instr, input logic [4:0] s1,
                             input logic r1, input logic [4:0] s2, input logic r2,
                             input logic [4:0] dst, input logic wbv, input logic [4:0] wbt,
                             input logic irdy, input logic fl, input logic rstn);
        bit found;
        int w;
        int free_slot;
        bit accept;
        bit issued;
        if (!rstn) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_slot_v = 0; m_slot_instr = '0; m_slot_dst = '0; m_slot_id = 0;
            m_rr = 0; m_count = 0; m_known = 1;
            return;
        end
        if (fl) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            m_slot_v = 0; m_rr = 0; m_count = 0;
            return;
        end
        found = 0; w = 0;
        for (int k = 0; k < DEPTH; k++) begin
            int idx;
            idx = (m_rr + k) % DEPTH;
            if (!found && m_valid[idx] && m_r1[idx] && m_r2[idx]) begin
                found = 1; w = idx;
            end
        end
        accept = av && (m_count < DEPTH);
        free_slot = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_valid[i] && free_slot < 0) free_slot = i;
        end
        issued = 0;
        if ((!m_slot_v || irdy) && found) begin
            m_slot_v = 1; m_slot_instr = m_instr[w]; m_slot_dst = m_dst[w]; m_slot_id = w;
            m_valid[w] = 0; m_rr = (w + 1) % DEPTH; issued = 1;
        end else if (irdy) begin
            m_slot_v = 0;
        end
        if (wbv) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i] && m_s1[i] == wbt) m_r1[i] = 1;
                if (m_valid[i] && m_s2[i] == wbt) m_r2[i] = 1;
            end
        end
        if (accept) begin
            m_valid[free_slot] = 1; m_instr[free_slot] = instr; m_dst[free_slot] = dst;
            m_s1[free_slot] = s1; m_s2[free_slot] = s2;
            m_r1[free_slot] = r1 || (s1 == 5'd0) || (wbv && wbt == s1);
            m_r2[free_slot] = r2 || (s2 == 5'd0) || (wbv && wbt == s2);
        end
        m_count = m_count + int'(accept) - int'(issued);
    endtask

    // Drive one cycle of inputs, publish expectations, step the model and
    // wait until just after the next rising edge.
    task automatic applyStimulus(input logic av, input logic [31:0] instr, input logic [4:0] s1,
                                 input logic r1, input logic [4:0] s2, input logic r2,
                                 input logic [4:0] dst, input logic wbv, input logic [4:0] wbt,
                                 input logic irdy, input logic fl, input logic rstn);
        resetn             = rstn;
        bus.flush          = fl;
        bus.alloc_valid    = av;
        bus.alloc_instr    = instr;
        bus.alloc_src1     = s1;
        bus.alloc_src1_rdy = r1;
        bus.alloc_src2     = s2;
        bus.alloc_src2_rdy = r2;
        bus.alloc_dst      = dst;
        bus.wb_valid       = wbv;
        bus.wb_tag         = wbt;
        bus.issue_ready    = irdy;

        chk_en  = m_known;
        e_iv    = m_slot_v;
        e_count = m_count;
        e_full  = (m_count == DEPTH);
        e_empty = (m_count == 0);
        e_ar    = (m_count != DEPTH) && !fl;
        e_instr = m_slot_instr;
        e_dst   = m_slot_dst;
        e_id    = m_slot_id;
        if (m_known && m_slot_v && irdy) begin
            exp_q.push_back('{instr: m_slot_instr, dst: m_slot_dst, id: m_slot_id});
        end
        modelEdge(av, instr, s1, r1, s2, r2, dst, wbv, wbt, irdy, fl, rstn);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic irdy);
        applyStimulus(1'b0, '0, '0, 1'b1, '0, 1'b1, '0, 1'b0, '0, irdy, 1'b0, 1'b1);
    endtask

    task automatic doAlloc(input logic [31:0] instr, input logic [4:0] s1, input logic r1,
                           input logic [4:0] s2, input logic r2, input logic [4:0] dst,
                           input logic irdy);
        applyStimulus(1'b1, instr, s1, r1, s2, r2, dst, 1'b0, '0, irdy, 1'b0, 1'b1);
    endtask

    task automatic doWb(input logic [4:0] tag, input logic irdy);
        applyStimulus(1'b0, '0, '0, 1'b1, '0, 1'b1, '0, 1'b1, tag, irdy, 1'b0, 1'b1);
    endtask

    task automatic doFlush();
        applyStimulus(1'b0, '0, '0, 1'b1, '0, 1'b1, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic checkIdOrder(input string name, input int expq[$]);
        checkOutput({name, "_len"}, 64'(obs_ids.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < obs_ids.size(); i++) begin
            checkOutput(name, 64'(obs_ids[i]), 64'(expq[i]));
        end
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on every
    // issue handshake.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("issue_valid", 64'(bus.issue_valid), 64'(e_iv));
            checkOutput("alloc_ready", 64'(bus.alloc_ready), 64'(e_ar));
            checkOutput("count", 64'(bus.count), 64'(e_count));
            checkOutput("full", 64'(bus.full), 64'(e_full));
            checkOutput("empty", 64'(bus.empty), 64'(e_empty));
            if (e_iv) begin
                checkOutput("slot_instr", 64'(bus.issue_instr), 64'(e_instr));
                checkOutput("slot_dst", 64'(bus.issue_dst), 64'(e_dst));
                checkOutput("slot_id", 64'(bus.issue_id), 64'(e_id));
            end
            if (bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
                obs_ids.push_back(int'(bus.issue_id));
                checkOutput("sb_expected_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    iss_t it;
                    it = exp_q.pop_front();
                    checkOutput("sb_instr", 64'(bus.issue_instr), 64'(it.instr));
                    checkOutput("sb_dst", 64'(bus.issue_dst), 64'(it.dst));
                    checkOutput("sb_id", 64'(bus.issue_id), 64'(it.id));
                end
            end
        end
    end

    initial begin
        int          exp_ids[$];
        logic [31:0] held_instr;
        logic [3:0]  held_id;
        logic        r_av, r_r1, r_r2, r_wbv, r_irdy, r_fl, r_rstn;
        logic [4:0]  r_s1, r_s2, r_dst, r_wbt;
        logic [31:0] r_instr;

        resetn = 1'b0; bus.flush = 1'b0; bus.alloc_valid = 1'b0; bus.alloc_instr = '0;
        bus.alloc_src1 = '0; bus.alloc_src1_rdy = 1'b0; bus.alloc_src2 = '0;
        bus.alloc_src2_rdy = 1'b0; bus.alloc_dst = '0; bus.wb_valid = 1'b0;
        bus.wb_tag = '0; bus.issue_ready = 1'b0;
        @(posedge clk);
        #2;

        $display("[TB] reset");
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_issue_valid", 64'(bus.issue_valid), 64'(0));
        checkOutput("rst_count", 64'(bus.count), 64'(0));
        checkOutput("rst_empty", 64'(bus.empty), 64'(1));
        checkOutput("rst_alloc_ready", 64'(bus.alloc_ready), 64'(1));

        $display("[TB] ready at dispatch");
        doAlloc(32'h00A00093, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1);
        checkOutput("rad_not_yet", 64'(bus.issue_valid), 64'(0));
        idle(1'b1);
        checkOutput("rad_valid", 64'(bus.issue_valid), 64'(1));
        checkOutput("rad_instr", 64'(bus.issue_instr), 64'h00A00093);
        checkOutput("rad_dst", 64'(bus.issue_dst), 64'(1));
        checkOutput("rad_id", 64'(bus.issue_id), 64'(0));
        checkOutput("rad_count", 64'(bus.count), 64'(0));
        idle(1'b1);

        $display("[TB] wakeup and allocation bypass");
        doAlloc(32'h11, 5'd5, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1);
        repeat (10) idle(1'b1);
        checkOutput("wk_waiting", 64'(bus.issue_valid), 64'(0));
        doWb(5'd5, 1'b1);
        checkOutput("wk_no_same_cycle", 64'(bus.issue_valid), 64'(0));
        idle(1'b1);
        checkOutput("wk_valid", 64'(bus.issue_valid), 64'(1));
        checkOutput("wk_instr", 64'(bus.issue_instr), 64'h11);
        idle(1'b1);
        applyStimulus(1'b1, 32'h22, 5'd6, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        checkOutput("byp_valid", 64'(bus.issue_valid), 64'(1));
        checkOutput("byp_instr", 64'(bus.issue_instr), 64'h22);
        idle(1'b1);

        $display("[TB] full and backpressure");
        for (int i = 0; i < DEPTH; i++) doAlloc(32'h300 + i, 5'd7, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
        checkOutput("full_flag", 64'(bus.full), 64'(1));
        checkOutput("full_alloc_ready", 64'(bus.alloc_ready), 64'(0));
        checkOutput("full_count", 64'(bus.count), 64'(16));
        doAlloc(32'h3FF, 5'd0, 1'b1, 5'd0, 1'b1, 5'd5, 1'b0);
        checkOutput("full_17th_dropped", 64'(bus.count), 64'(16));
        doFlush();
        doAlloc(32'h400, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b0);
        doAlloc(32'h401, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b0);
        idle(1'b0);
        held_instr = bus.issue_instr;
        held_id    = bus.issue_id;
        repeat (3) idle(1'b0);
        checkOutput("hold_instr", 64'(bus.issue_instr), 64'h400);
        checkOutput("hold_id", 64'(bus.issue_id), 64'(0));
        checkOutput("hold_stable", {held_instr, 28'(held_id)}, {bus.issue_instr, 28'(bus.issue_id)});
        repeat (4) idle(1'b1);
        checkOutput("hold_drained", 64'(bus.empty), 64'(1));

        $display("[TB] round robin");
        doFlush();
        obs_ids.delete();
        for (int i = 0; i < 4; i++) doAlloc(32'h500 + i, 5'd9, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
        doWb(5'd9, 1'b1);
        repeat (8) idle(1'b1);
        exp_ids = {0, 1, 2, 3};
        checkIdOrder("rr_order_a", exp_ids);
        doFlush();
        obs_ids.delete();
        for (int i = 0; i < 2; i++) doAlloc(32'h510 + i, 5'd9, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
        doWb(5'd9, 1'b1);
        repeat (6) idle(1'b1);
        obs_ids.delete();
        for (int i = 0; i < 4; i++) doAlloc(32'h520 + i, 5'd9, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
        doWb(5'd9, 1'b1);
        repeat (8) idle(1'b1);
        exp_ids = {2, 3, 0, 1};
        checkIdOrder("rr_order_b", exp_ids);

        $display("[TB] flush");
        doFlush();
        doAlloc(32'h600, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b0);
        for (int i = 0; i < 6; i++) doAlloc(32'h610 + i, 5'd11, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        checkOutput("fl_pre_count", 64'(bus.count), 64'(6));
        checkOutput("fl_pre_valid", 64'(bus.issue_valid), 64'(1));
        applyStimulus(1'b1, 32'h6FF, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 5'd11, 1'b0, 1'b1, 1'b1);
        checkOutput("fl_count", 64'(bus.count), 64'(0));
        checkOutput("fl_issue_valid", 64'(bus.issue_valid), 64'(0));
        repeat (5) idle(1'b1);
        checkOutput("fl_no_late_issue", 64'(bus.issue_valid), 64'(0));
        checkOutput("fl_still_empty", 64'(bus.count), 64'(0));

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            r_av    = ($urandom_range(0, 99) < 60);
            r_instr = $urandom;
            r_s1    = 5'($urandom_range(0, 7));
            r_r1    = ($urandom_range(0, 99) < 40);
            r_s2    = 5'($urandom_range(0, 7));
            r_r2    = ($urandom_range(0, 99) < 40);
            r_dst   = 5'($urandom_range(0, 31));
            r_wbv   = ($urandom_range(0, 99) < 50);
            r_wbt   = 5'($urandom_range(0, 7));
            r_irdy  = ($urandom_range(0, 99) < 65);
            r_fl    = ($urandom_range(0, 99) < 2);
            r_rstn  = ($urandom_range(0, 299) != 0);
            applyStimulus(r_av, r_instr, r_s1, r_r1, r_s2, r_r2, r_dst, r_wbv, r_wbt,
                          r_irdy, r_fl, r_rstn);
        end

        // Wake every tag the random phase could have used, then let it drain.
        for (int t = 1; t < 8; t++) doWb(5'(t), 1'b1);
        repeat (40) idle(1'b1);
        checkOutput("drain_empty", 64'(bus.empty), 64'(1));
        checkOutput("sb_all_consumed", 64'(exp_q.size()), 64'(0));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
